// File: rtl/zbt_ft_sram_resp.sv
// rtl/zbt_ft_sram_resp.sv - flow-through ZBT SRAM responder with burst sequencing and late-write commit

`ifndef ADDR_BITS
`define ADDR_BITS 20
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module zbt_ft_sram_resp #(
    parameter int ADDR_BITS = `ADDR_BITS,
    parameter int DATA_BITS = `DATA_BITS,
    parameter int MEM_AW    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 rw_n,
    input  logic                 ld_n,
    input  logic                 cke_n,
    input  logic                 ce_n,
    input  logic                 ce2,
    input  logic                 ce2_n,
    input  logic                 bwa_n,
    input  logic                 bwb_n,
    input  logic                 bwc_n,
    input  logic                 bwd_n,
    input  logic                 oe_n,
    input  logic                 lbo_n,
    input  logic                 zz,
    input  logic [DATA_BITS-1:0] dq_in,
    output logic [DATA_BITS-1:0] dq_out,
    output logic                 dq_oe
);

    localparam int LW = DATA_BITS / 4;

    // Access currently in flight; a write access doubles as the pending write
    // whose data arrives at the next active edge.
    typedef enum logic [1:0] {
        OP_DESEL = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_t;

    op_t                  r_op;
    op_t                  w_nxt_op;
    logic [ADDR_BITS-1:0] r_base;
    logic [ADDR_BITS-1:0] w_nxt_base;
    logic [1:0]           r_cnt;
    logic [1:0]           w_nxt_cnt;
    logic [3:0]           r_mask;
    logic [3:0]           w_nxt_mask;
    logic [3:0]           w_bw;
    logic                 w_active;
    logic                 w_sel;
    logic                 w_commit;
    logic [MEM_AW-1:0]    w_cur_idx;
    logic [MEM_AW-1:0]    w_nxt_idx;
    logic [DATA_BITS-1:0] w_rd_word;
    logic [DATA_BITS-1:0] r_dq_out;
    logic [DATA_BITS-1:0] r_mem [0:(1<<MEM_AW)-1];
    logic                 w_unused_base;

    // Word index inside the array: burst beats wrap within the aligned 4-word block.
    function automatic logic [MEM_AW-1:0] eff_idx(
        input logic [MEM_AW-1:0] base,
        input logic [1:0]        cnt,
        input logic              lbo
    );
        logic [1:0] lo;
        lo = lbo ? (base[1:0] ^ cnt) : (base[1:0] + cnt);
        return {base[MEM_AW-1:2], lo};
    endfunction

    assign w_active      = !cke_n && !zz;
    assign w_sel         = !ce_n && ce2 && !ce2_n;
    assign w_bw          = {bwd_n, bwc_n, bwb_n, bwa_n};
    assign w_commit      = w_active && (r_op == OP_WRITE);
    assign w_cur_idx     = eff_idx(r_base[MEM_AW-1:0], r_cnt, lbo_n);
    assign w_nxt_idx     = eff_idx(w_nxt_base[MEM_AW-1:0], w_nxt_cnt, lbo_n);
    assign w_unused_base = ^r_base[ADDR_BITS-1:MEM_AW];

    // Next access state: load, deselect or burst advance on active edges only.
    always_comb begin
        w_nxt_op   = r_op;
        w_nxt_base = r_base;
        w_nxt_cnt  = r_cnt;
        w_nxt_mask = r_mask;
        if (w_active) begin
            if (!ld_n) begin
                if (w_sel) begin
                    w_nxt_op   = rw_n ? OP_READ : OP_WRITE;
                    w_nxt_base = addr;
                    w_nxt_cnt  = 2'd0;
                    w_nxt_mask = w_bw;
                end else begin
                    w_nxt_op = OP_DESEL;
                end
            end else if (r_op != OP_DESEL) begin
                w_nxt_cnt  = r_cnt + 2'd1;
                w_nxt_mask = w_bw;
            end
        end
    end

    // Access state register; reset drops any pending write by deselecting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_DESEL;
            r_base <= '0;
            r_cnt  <= 2'd0;
            r_mask <= 4'hF;
        end else begin
            r_op   <= w_nxt_op;
            r_base <= w_nxt_base;
            r_cnt  <= w_nxt_cnt;
            r_mask <= w_nxt_mask;
        end
    end

    // Late-write commit of the captured data lanes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int l = 0; l < 4; l++) begin
                if (!r_mask[l]) begin
                    r_mem[w_cur_idx][l*LW +: LW] <= dq_in[l*LW +: LW];
                end
            end
        end
    end

    // Read word with same-edge write lanes forwarded so back-to-back RAW needs no turnaround.
    always_comb begin
        w_rd_word = r_mem[w_nxt_idx];
        if (w_commit && (w_cur_idx == w_nxt_idx)) begin
            for (int l = 0; l < 4; l++) begin
                if (!r_mask[l]) begin
                    w_rd_word[l*LW +: LW] = dq_in[l*LW +: LW];
                end
            end
        end
    end

    // Flow-through output register: loads only for read beats, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq_out <= '0;
        end else if (w_active && (w_nxt_op == OP_READ)) begin
            r_dq_out <= w_rd_word;
        end
    end

    assign dq_out = r_dq_out;
    assign dq_oe  = (r_op == OP_READ) && !oe_n && !zz;

endmodule

// File: tb/tb_zbt_ft_sram_resp.sv
// tb/tb_zbt_ft_sram_resp.sv - scoreboard bench for zbt_ft_sram_resp against a behavioural SRAM model

module tb_zbt_ft_sram_resp;

    localparam int AB  = 20;
    localparam int DB  = 32;
    localparam int MAW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AB-1:0] addr = '0;
    logic          rw_n = 1'b1;
    logic          ld_n = 1'b0;
    logic          cke_n = 1'b0;
    logic          ce_n = 1'b1;
    logic          ce2 = 1'b1;
    logic          ce2_n = 1'b0;
    logic          bwa_n = 1'b1;
    logic          bwb_n = 1'b1;
    logic          bwc_n = 1'b1;
    logic          bwd_n = 1'b1;
    logic          oe_n = 1'b0;
    logic          lbo_n = 1'b0;
    logic          zz = 1'b0;
    logic [DB-1:0] dq_in = '0;
    logic [DB-1:0] dq_out;
    logic          dq_oe;

    always #5 clk = ~clk;

    zbt_ft_sram_resp #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_AW(MAW)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rw_n(rw_n), .ld_n(ld_n),
        .cke_n(cke_n), .ce_n(ce_n), .ce2(ce2), .ce2_n(ce2_n),
        .bwa_n(bwa_n), .bwb_n(bwb_n), .bwc_n(bwc_n), .bwd_n(bwd_n),
        .oe_n(oe_n), .lbo_n(lbo_n), .zz(zz), .dq_in(dq_in),
        .dq_out(dq_out), .dq_oe(dq_oe)
    );

    typedef struct packed {
        logic          oe;
        logic [DB-1:0] out;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: op 0 = none, 1 = read, 2 = write; memory covers the 64-word test region.
    int            m_op = 0;
    logic [AB-1:0] m_base = '0;
    int            m_cnt = 0;
    logic [3:0]    m_mask = 4'hF;
    logic [DB-1:0] m_out = '0;
    logic [DB-1:0] m_mem [64];
    logic [DB-1:0] nxt_din = '0;
    bit            nxt_valid = 0;

    function automatic int midx(input logic [AB-1:0] b, input int c, input logic lbo);
        int bl;
        int lo;
        bl = int'(b[1:0]);
        lo = lbo ? (bl ^ c) : ((bl + c) % 4);
        return int'(b[5:2]) * 4 + lo;
    endfunction

    // Apply the driven inputs for one edge, predict its effect, push the expectation.
    task automatic step();
        exp_t e;
        int   a;
        dq_in = nxt_valid ? nxt_din : DB'($urandom);
        if (!rst_n) begin
            m_op = 0; m_cnt = 0; m_base = '0; m_mask = 4'hF; m_out = '0;
            nxt_valid = 0;
        end else if (!cke_n && !zz) begin
            if (m_op == 2) begin
                a = midx(m_base, m_cnt, lbo_n);
                for (int l = 0; l < 4; l++)
                    if (!m_mask[l]) m_mem[a][l*8 +: 8] = dq_in[l*8 +: 8];
            end
            nxt_valid = 0;
            if (!ld_n) begin
                if (!ce_n && ce2 && !ce2_n) begin
                    m_base = addr; m_cnt = 0; m_op = rw_n ? 1 : 2;
                    m_mask = {bwd_n, bwc_n, bwb_n, bwa_n};
                end else begin
                    m_op = 0;
                end
            end else if (m_op != 0) begin
                m_cnt = (m_cnt + 1) % 4;
                m_mask = {bwd_n, bwc_n, bwb_n, bwa_n};
            end
            if (m_op == 1) m_out = m_mem[midx(m_base, m_cnt, lbo_n)];
        end
        e.oe  = rst_n && (m_op == 1) && !oe_n && !zz;
        e.out = m_out;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst_n = 1'b1; cke_n = 1'b0; zz = 1'b0; ld_n = 1'b0; oe_n = 1'b0;
        ce_n = 1'b1; ce2 = 1'b1; ce2_n = 1'b0; rw_n = 1'b1;
        {bwd_n, bwc_n, bwb_n, bwa_n} = 4'hF;
        addr = AB'($urandom);
    endtask

    task automatic ld(input logic rw, input logic [AB-1:0] a, input logic [3:0] bw);
        set_idle();
        ce_n = 1'b0; rw_n = rw; addr = a;
        {bwd_n, bwc_n, bwb_n, bwa_n} = bw;
        step();
    endtask

    task automatic adv(input logic [3:0] bw);
        set_idle();
        ld_n = 1'b1;
        {bwd_n, bwc_n, bwb_n, bwa_n} = bw;
        step();
    endtask

    task automatic desel();
        set_idle();
        step();
    endtask

    task automatic stall();
        set_idle();
        cke_n = 1'b1;
        step();
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [3:0] bw);
        ld(1'b0, a, bw);
        nxt_din = d;
        nxt_valid = 1;
    endtask

    function automatic logic [AB-1:0] rnd_addr();
        logic [AB-1:0] r;
        r = AB'($urandom);
        return r & 20'hFFC3F;
    endfunction

    // Monitor: every clock the DUT presents dq_oe/dq_out; compare against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (dq_oe !== e.oe) begin
                    errors++;
                    $display("FAIL dq_oe t=%0t got %b exp %b", $time, dq_oe, e.oe);
                end
                checks++;
                if (dq_out !== e.out) begin
                    errors++;
                    $display("FAIL dq_out t=%0t got %h exp %h", $time, dq_out, e.out);
                end
            end
        end
    end

    initial begin
        int r;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (dq_out !== '0 || dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got out=%h oe=%b exp out=0 oe=0", dq_out, dq_oe);
        end

        // Fill the 64-word region with linear write bursts.
        lbo_n = 1'b0;
        for (int b = 0; b < 16; b++) begin
            wr(AB'(b * 4), DB'($urandom), 4'h0);
            for (int k = 0; k < 3; k++) begin
                adv(4'h0);
                nxt_din = DB'($urandom);
                nxt_valid = 1;
            end
        end
        desel();

        // Basic write then read.
        wr(20'h00010, 32'hDEADBEEF, 4'h0);
        desel();
        ld(1'b1, 20'h00010, 4'hF);
        desel();

        // Burst orders.
        lbo_n = 1'b0; ld(1'b1, 20'h00006, 4'hF); repeat (3) adv(4'hF);
        lbo_n = 1'b1; ld(1'b1, 20'h00006, 4'hF); repeat (3) adv(4'hF);
        ld(1'b1, 20'h00005, 4'hF); repeat (3) adv(4'hF);
        lbo_n = 1'b0;
        desel();

        // Single byte-lane write.
        wr(20'h00020, 32'h11223344, 4'h0);
        desel();
        wr(20'h00020, 32'hAABBCCDD, 4'b1101);
        desel();
        ld(1'b1, 20'h00020, 4'hF);
        desel();

        // Read immediately after write to the same word.
        wr(20'h00030, 32'h00000055, 4'h0);
        ld(1'b1, 20'h00030, 4'hF);
        desel();

        // Stalls between write address and data edge.
        wr(20'h00031, 32'hCAFEF00D, 4'h0);
        stall();
        stall();
        desel();
        ld(1'b1, 20'h00031, 4'hF);
        set_idle(); ld_n = 1'b1; oe_n = 1'b1; step();
        set_idle(); ld_n = 1'b1; zz = 1'b1; step();
        desel();

        // Reset between write address and data edge discards the write.
        wr(20'h00032, 32'h0BADBEEF, 4'h0);
        set_idle(); rst_n = 1'b0; step();
        ld(1'b1, 20'h00032, 4'hF);
        desel();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            set_idle();
            case (r)
                0, 1, 2: begin
                    lbo_n = 1'($urandom); ce_n = 1'b0; rw_n = 1'b1; addr = rnd_addr();
                end
                3, 4: begin
                    lbo_n = 1'($urandom); ce_n = 1'b0; rw_n = 1'b0; addr = rnd_addr();
                    {bwd_n, bwc_n, bwb_n, bwa_n} = 4'($urandom);
                end
                5, 6: begin
                    ld_n = 1'b1;
                    {bwd_n, bwc_n, bwb_n, bwa_n} = 4'($urandom);
                end
                7: begin
                    ce_n = 1'($urandom); ce2 = 1'($urandom); ce2_n = 1'($urandom);
                    if (!ce_n && ce2 && !ce2_n) ce2 = 1'b0;
                    rw_n = 1'($urandom);
                end
                8: begin
                    cke_n = 1'b1; ld_n = 1'($urandom); ce_n = 1'b0;
                end
                default: begin
                    zz = 1'b1; ld_n = 1'($urandom); ce_n = 1'b0;
                end
            endcase
            if ($urandom_range(0, 7) == 0) oe_n = 1'b1;
            step();
        end
        repeat (3) desel();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
